// File: rtl/reg_w1s_dispatch.sv
// Write-1-to-set command register: pending bits are issued one at a time over req/ack
// in round-robin order. Define REG_W1S_DISPATCH_TMO_EN to enable the REQ-phase timeout.
module reg_w1s_dispatch #(
    parameter int BITS_W  = 8,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [BITS_W-1:0] w_dat,
    input  logic              clr,
    output logic [BITS_W-1:0] pend,
    output logic              cmd_req,
    output logic [BITS_W-1:0] cmd_vec,
    input  logic              cmd_ack,
    output logic              busy,
    output logic              done_pulse,
    output logic              tmo_pulse
);

    localparam int PTR_W = $clog2(BITS_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    if (BITS_W < 2 || TMO_CYC < 1 || TMO_CYC > (1 << TMO_W) - 1) begin : g_param_check
        $error("reg_w1s_dispatch: BITS_W must be >= 2 and TMO_CYC within 1 .. 2^TMO_W-1");
    end

    state_t            state_q;
    logic [BITS_W-1:0] pend_q;
    logic [BITS_W-1:0] pend_d;
    logic [BITS_W-1:0] cmd_vec_q;
    logic              cmd_req_q;
    logic              done_q;
    logic              tmo_q;
    logic [PTR_W-1:0]  ptr_q;

    logic [BITS_W-1:0] grant_vec;
    logic [BITS_W-1:0] take;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  ptr_next;
    logic              grant_found;
    logic [PTR_W:0]    scan_sum;
    logic [PTR_W-1:0]  scan_idx;
    logic              tmo_hit;

    // Round-robin scan: first pending bit at or after ptr, wrapping past BITS_W-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int i = 0; i < BITS_W; i++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (scan_sum >= (PTR_W+1)'(BITS_W)) begin
                scan_sum = scan_sum - (PTR_W+1)'(BITS_W);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!grant_found && pend_q[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        grant_vec            = '0;
        grant_vec[grant_idx] = grant_found;
    end

    assign ptr_next = (grant_idx == PTR_W'(BITS_W - 1)) ? '0 : grant_idx + 1'b1;
    assign take     = (state_q == IDLE) ? grant_vec : '0;

    // A same-cycle write always survives both clr and the grant.
    assign pend_d = ((clr ? '0 : pend_q) & ~take) | (w_en ? w_dat : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

`ifdef REG_W1S_DISPATCH_TMO_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    // Held at zero outside REQ, so every REQ entry starts counting from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != REQ) begin
            tmo_cnt_q <= '0;
        end else if (!cmd_ack && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_req_q <= 1'b0;
            cmd_vec_q <= '0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            ptr_q     <= '0;
        end else begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        cmd_vec_q <= grant_vec;
                        cmd_req_q <= 1'b1;
                        ptr_q     <= ptr_next;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    // Ack takes priority over a coincident timeout.
                    if (cmd_ack) begin
                        cmd_req_q <= 1'b0;
                        cmd_vec_q <= '0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if (tmo_hit) begin
                        cmd_req_q <= 1'b0;
                        cmd_vec_q <= '0;
                        tmo_q     <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pend       = pend_q;
    assign cmd_req    = cmd_req_q;
    assign cmd_vec    = cmd_vec_q;
    assign done_pulse = done_q;
    assign tmo_pulse  = tmo_q;
    assign busy       = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_reg_w1s_dispatch.sv
// Bench for reg_w1s_dispatch: directed vectors, a cycle model of the command rules,
// and literal expectations for the documented scenarios.
module tb_reg_w1s_dispatch;

    localparam int TB_TMO_CYC = 5;
`ifdef REG_W1S_DISPATCH_TMO_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_en = 1'b0;
    logic [7:0] w_dat = 8'h00;
    logic       clr = 1'b0;
    logic [7:0] pend;
    logic       cmd_req;
    logic [7:0] cmd_vec;
    logic       cmd_ack = 1'b0;
    logic       busy;
    logic       done_pulse;
    logic       tmo_pulse;

    int n_checks = 0;
    int n_err    = 0;

    reg_w1s_dispatch #(
        .BITS_W (8),
        .TMO_W  (8),
        .TMO_CYC(TB_TMO_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_en      (w_en),
        .w_dat     (w_dat),
        .clr       (clr),
        .pend      (pend),
        .cmd_req   (cmd_req),
        .cmd_vec   (cmd_vec),
        .cmd_ack   (cmd_ack),
        .busy      (busy),
        .done_pulse(done_pulse),
        .tmo_pulse (tmo_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: pending set, the in-flight bit index (-1 when none), cycles spent requesting,
    // the one-cycle retire gap, and the round-robin start position.
    logic [7:0] m_pend = 8'h00;
    int         m_cur  = -1;
    int         m_age  = 0;
    bit         m_cool = 1'b0;
    int         m_ptr  = 0;
    bit         m_done = 1'b0;
    bit         m_tmo  = 1'b0;

    logic [7:0] n_pend;
    int         n_cur, n_age, n_ptr;
    bit         n_cool, n_done, n_tmo;

    function automatic void model_step(
        input  logic [7:0] pend_i, input int cur_i, input int age_i, input bit cool_i,
        input  int ptr_i, input logic we, input logic [7:0] wd, input logic cl, input logic ack,
        output logic [7:0] pend_o, output int cur_o, output int age_o, output bit cool_o,
        output int ptr_o, output bit done_o, output bit tmo_o);
        logic [7:0] take;
        logic [2:0] b3;
        take   = 8'h00;
        cur_o  = cur_i;
        age_o  = age_i;
        cool_o = 1'b0;
        ptr_o  = ptr_i;
        done_o = 1'b0;
        tmo_o  = 1'b0;
        if (cur_i >= 0) begin
            if (ack) begin
                cur_o = -1; done_o = 1'b1; cool_o = 1'b1;
            end else if (TMO_ON && age_i == TB_TMO_CYC - 1) begin
                cur_o = -1; tmo_o = 1'b1; cool_o = 1'b1;
            end else begin
                age_o = age_i + 1;
            end
        end else if (!cool_i && pend_i != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                b3 = 3'((ptr_i + k) % 8);
                if (cur_o < 0 && pend_i[b3]) begin
                    cur_o    = int'(b3);
                    age_o    = 0;
                    ptr_o    = (int'(b3) + 1) % 8;
                    take[b3] = 1'b1;
                end
            end
        end
        pend_o = ((cl ? 8'h00 : pend_i) & ~take) | (we ? wd : 8'h00);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 8'h00; m_cur <= -1; m_age <= 0; m_cool <= 1'b0;
            m_ptr <= 0; m_done <= 1'b0; m_tmo <= 1'b0;
        end else begin
            model_step(m_pend, m_cur, m_age, m_cool, m_ptr, w_en, w_dat, clr, cmd_ack,
                       n_pend, n_cur, n_age, n_cool, n_ptr, n_done, n_tmo);
            m_pend <= n_pend; m_cur <= n_cur; m_age <= n_age; m_cool <= n_cool;
            m_ptr <= n_ptr; m_done <= n_done; m_tmo <= n_tmo;
        end
    end

    // Per-cycle comparison against the model, plus a log of issued commands.
    logic [7:0] issued[$];
    logic       req_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("pend", pend, m_pend);
            check("cmd_req", cmd_req, (m_cur >= 0) ? 1 : 0);
            check("cmd_vec", cmd_vec, (m_cur >= 0) ? (8'h01 << m_cur) : 8'h00);
            check("busy", busy, (m_cur >= 0 || m_cool || m_pend != 8'h00) ? 1 : 0);
            check("done_pulse", done_pulse, m_done);
            check("tmo_pulse", tmo_pulse, m_tmo);
            if (cmd_req && !req_prev) issued.push_back(cmd_vec);
        end
        req_prev <= cmd_req;
    end

    function automatic logic [7:0] issued_at(input int i);
        if (i < issued.size()) return issued[i];
        return 8'hEE;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        w_en = 1'b0; w_dat = 8'h00; clr = 1'b0; cmd_ack = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        issued.delete();
    endtask

    task automatic write(input logic [7:0] d);
        w_en = 1'b1; w_dat = d;
        tick();
        w_en = 1'b0; w_dat = 8'h00;
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!cmd_req && n < max) begin tick(); n++; end
        check("wait_req", cmd_req, 1);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin tick(); n++; end
        check("wait_idle", busy, 0);
    endtask

    initial begin
        int n;
        tick();
        check("rst_pend", pend, 8'h00);
        check("rst_req", cmd_req, 0);
        check("rst_vec", cmd_vec, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done_pulse, 0);
        check("rst_tmo", tmo_pulse, 0);

        // Single command with latency checks
        do_reset();
        write(8'h04);
        check("t1_pend_c1", pend, 8'h04);
        check("t1_req_c1", cmd_req, 0);
        tick();
        check("t1_req_c2", cmd_req, 1);
        check("t1_vec_c2", cmd_vec, 8'h04);
        check("t1_pend_c2", pend, 8'h00);
        tick();
        check("t1_req_c3", cmd_req, 1);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check("t1_req_c4", cmd_req, 0);
        check("t1_done_c4", done_pulse, 1);
        check("t1_busy_c4", busy, 1);
        tick();
        check("t1_busy_c5", busy, 0);
        check("t1_done_c5", done_pulse, 0);

        // Round-robin with wrap of ptr after bit 7
        do_reset();
        cmd_ack = 1'b1;
        write(8'h81);
        wait_idle(20);
        check("rr1_count", issued.size(), 2);
        check("rr1_first", issued_at(0), 8'h01);
        check("rr1_second", issued_at(1), 8'h80);
        issued.delete();
        write(8'h81);
        wait_idle(20);
        check("rr2_count", issued.size(), 2);
        check("rr2_first", issued_at(0), 8'h01);
        check("rr2_second", issued_at(1), 8'h80);
        cmd_ack = 1'b0;

        // In-flight rewrite with clr, then clr alone during REQ
        do_reset();
        write(8'h02);
        wait_req(10);
        w_en = 1'b1; w_dat = 8'h02; clr = 1'b1;
        tick();
        w_en = 1'b0; w_dat = 8'h00; clr = 1'b0;
        check("rw_pend", pend, 8'h02);
        check("rw_req", cmd_req, 1);
        check("rw_vec", cmd_vec, 8'h02);
        cmd_ack = 1'b1;
        tick();
        wait_idle(20);
        cmd_ack = 1'b0;
        check("rw_count", issued.size(), 2);
        check("rw_reissue", issued_at(1), 8'h02);
        write(8'h0A);
        wait_req(10);
        check("clr_vec", cmd_vec, 8'h08);
        check("clr_pend_before", pend, 8'h02);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_pend", pend, 8'h00);
        check("clr_req_held", cmd_req, 1);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check("clr_done", done_pulse, 1);
        wait_idle(10);
        repeat (4) tick();
        check("clr_no_reissue", issued.size(), 3);

        // Timeout without ack
        do_reset();
        write(8'h04);
        wait_req(10);
        n = 1;
`ifdef REG_W1S_DISPATCH_TMO_EN
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!cmd_req) break;
            n++;
        end
        check("tmo_req_len", n, 5);
        check("tmo_pulse", tmo_pulse, 1);
        check("tmo_no_done", done_pulse, 0);
        wait_idle(10);
        repeat (4) tick();
        check("tmo_no_requeue", issued.size(), 1);
        check("tmo_pend", pend, 8'h00);
`else
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!cmd_req) break;
            n++;
        end
        check("notmo_req_len", n, 13);
        check("notmo_pulse", tmo_pulse, 0);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check("notmo_done", done_pulse, 1);
        wait_idle(10);
`endif

        // Ack on the same cycle the timeout would fire
        do_reset();
        write(8'h04);
        wait_req(10);
        repeat (4) tick();
        check("col_req_c5", cmd_req, 1);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check("col_done", done_pulse, 1);
        check("col_tmo", tmo_pulse, 0);
        wait_idle(10);

        // Asynchronous reset in the middle of a request
        do_reset();
        write(8'hF0);
        wait_req(10);
        write(8'hF0);
        check("ar_pend_pre", pend, 8'hF0);
        check("ar_req_pre", cmd_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_pend", pend, 8'h00);
        check("ar_req", cmd_req, 0);
        check("ar_vec", cmd_vec, 8'h00);
        check("ar_busy", busy, 0);
        check("ar_done", done_pulse, 0);
        check("ar_tmo", tmo_pulse, 0);
        tick();
        rst_n = 1'b1;
        issued.delete();
        write(8'h10);
        check("ar2_pend", pend, 8'h10);
        check("ar2_req_c1", cmd_req, 0);
        tick();
        check("ar2_req_c2", cmd_req, 1);
        check("ar2_vec_c2", cmd_vec, 8'h10);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check("ar2_done", done_pulse, 1);
        wait_idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/reg_w1s_dispatch.md
# reg_w1s_dispatch

Software-to-hardware command register for the register bank. Software writes 1 to set command bits, and the block queues them as pending. Pending bits are issued one at a time to hardware over a req/ack handshake in round-robin order. Each bit is retired when hardware acknowledges it, or when the optional timeout expires. This block carries commands from software to hardware; status bits travel from hardware to software through the write-1-to-clear status registers.

## Interface
Parameters:
- BITS_W, 8, number of command bits (≥2)
- TMO_W, 8, timeout counter width
- TMO_CYC, 200, cycles in REQ before timeout (1 .. 2^TMO_W-1)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- w_en  input  1  software write strobe, single cycle
- w_dat  input  BITS_W  write data; 1 = set pending, 0 = no effect
- clr  input  1  drop all pending (not in-flight) commands
- pend  output  BITS_W  pending readback, registered
- cmd_req  output  1  command request to hardware, registered
- cmd_vec  output  BITS_W  one-hot in-flight command, held stable while cmd_req=1, 0 otherwise
- cmd_ack  input  1  hardware acknowledge, sampled only while cmd_req=1
- busy  output  1  state != IDLE or pend != 0
- done_pulse  output  1  one-cycle pulse when a command is acknowledged
- tmo_pulse  output  1  one-cycle pulse when a command times out

## Operation
- Reset values:
  - all outputs are 0
  - state = IDLE
  - round-robin pointer ptr = 0
  - timeout counter = 0
- Pending update, every cycle:
  - pend_next = ((clr ? 0 : pend) & ~take) | (w_en ? w_dat : 0)
  - take is the one-hot bit granted this cycle, or 0.
  - A write always wins over clr and over take in the same cycle.
- State machine IDLE -> REQ -> DONE -> IDLE:
  - IDLE: if pend != 0, grant the first set bit at or after ptr, wrapping from BITS_W-1 to 0.
    - Load the grant into cmd_vec, assert cmd_req, clear that pend bit, go to REQ.
    - Set ptr = granted index + 1, wrapping to 0.
    - If pend == 0, stay in IDLE.
  - REQ: hold cmd_req and cmd_vec.
    - On cmd_ack=1: drop cmd_req, clear cmd_vec, pulse done_pulse, go to DONE.
  - DONE: one idle cycle, then go to IDLE. cmd_ack is ignored here.
- Writing 1 to the bit that is currently in flight sets its pend bit again. The command is re-issued after the current one retires; it is never merged with the in-flight command.
- clr does not affect an in-flight command.
- cmd_ack while cmd_req=0 is ignored.

## Timing
- A write in cycle N makes pend visible in N+1.
  - If the FSM is IDLE, the grant happens in N+1 and cmd_req is high from N+2.
- cmd_ack sampled high in cycle M gives cmd_req=0 and done_pulse=1 in M+1, DONE in M+1, IDLE in M+2.
  - The next cmd_req rises no earlier than M+3.
  - Minimum command spacing is 3 cycles per command, including a 1-cycle ack.
- An ack in the same cycle cmd_req first rises is valid: req is high for 1 cycle.
- Timeout, when compiled in:
  - The counter clears on entry to REQ and increments each REQ cycle without ack.
  - When count == TMO_CYC-1 and cmd_ack=0: drop cmd_req, clear cmd_vec, pulse tmo_pulse, go to DONE. The command is discarded, not re-queued.
  - If ack and the timeout coincide in the same cycle, ack wins: done_pulse fires and tmo_pulse does not.
- Reset mid-operation clears pend, cmd_req, cmd_vec, both pulses and ptr immediately. No ack is owed afterwards.

## Configuration
- REG_W1S_DISPATCH_TMO_EN:
  - Defined: timeout counter present, behaviour as above.
  - Undefined: no counter, tmo_pulse tied to 0, REQ waits indefinitely for cmd_ack. TMO_W and TMO_CYC are unused.

## Test plan
- Single command, BITS_W=8:
  - Stimulus: write w_dat=8'h04 in cycle 0; hold ack until cmd_req has been high 2 cycles.
  - Required: pend=8'h04 at cycle 1; cmd_req=1 with cmd_vec=8'h04 from cycle 2; done_pulse 1 cycle after ack; pend=0; busy falls when IDLE is re-entered.
- Round-robin:
  - Stimulus: write 8'h81 with ack always 1.
  - Required: issue order 8'h01 then 8'h80.
  - Stimulus: write 8'h81 again.
  - Required: order 8'h01 then 8'h80 again, because ptr wrapped to 0 after bit 7.
- In-flight rewrite plus clr:
  - Stimulus: while 8'h02 is in REQ, write 8'h02 together with clr=1.
  - Required: pend=8'h02 (write wins); after ack, 8'h02 is re-issued.
  - Stimulus: clr alone during REQ.
  - Required: pend=0 and the in-flight command still completes.
- Timeout, macro defined, TMO_CYC=5:
  - Stimulus: no ack.
  - Required: cmd_req high exactly 5 cycles; tmo_pulse on the following cycle; done_pulse=0; bit not re-queued.
- Ack/timeout collision:
  - Stimulus: ack on the 5th REQ cycle, TMO_CYC=5.
  - Required: done_pulse=1 and tmo_pulse=0.
- Reset mid-REQ:
  - Stimulus: assert rst_n=0 asynchronously with pend=8'hF0 and cmd_req=1.
  - Required: all outputs 0 within the same cycle.
  - Stimulus: release reset, then write 8'h10.
  - Required: 8'h10 is issued with normal 2-cycle latency.
